// File: rtl/tile_layer_scroller_if.sv
// Bus bundle for the scrolling tile layer: line control, VRAM/tile-ROM ports and pixel stream.
// The master side is the video timing/memory environment; the slave side is the scroller.
interface tile_layer_scroller_if #(
   parameter int MAP_COLS_LOG2 = 5,
   parameter int MAP_ROWS_LOG2 = 5,
   parameter int BPP           = 4,
   parameter int CODE_W        = 10
) ();
   logic                               line_start;
   logic [MAP_ROWS_LOG2+2:0]           line_y;
   logic [MAP_COLS_LOG2+2:0]           scroll_x;
   logic [MAP_ROWS_LOG2+2:0]           scroll_y;
   logic [MAP_COLS_LOG2+MAP_ROWS_LOG2-1:0] map_addr;
   logic [15:0]                        map_data;
   logic [CODE_W+2:0]                  rom_addr;
   logic [8*BPP-1:0]                   rom_data;
   logic                               pix_en;
   logic                               pixel_valid;
   logic [BPP-1:0]                     pixel_data;
   logic                               busy;

   modport master (
      output line_start, line_y, scroll_x, scroll_y, map_data, rom_data, pix_en,
      input  map_addr, rom_addr, pixel_valid, pixel_data, busy
   );

   modport slave (
      input  line_start, line_y, scroll_x, scroll_y, map_data, rom_data, pix_en,
      output map_addr, rom_addr, pixel_valid, pixel_data, busy
   );
endinterface

// File: rtl/tile_layer_scroller.sv
// Scrolling tile layer: fetches map entries and tile rows one tile ahead and streams LINE_W pixels.
// Define TILE_LAYER_FLIP_EN to enable per-tile horizontal/vertical flip.
module tile_layer_scroller #(
   parameter int MAP_COLS_LOG2 = 5,
   parameter int MAP_ROWS_LOG2 = 5,
   parameter int BPP           = 4,
   parameter int CODE_W        = 10,
   parameter int LINE_W        = 256
) (
   input logic               clk,
   input logic               reset,
   tile_layer_scroller_if.slave bus
);
   localparam int MC    = MAP_COLS_LOG2;
   localparam int MR    = MAP_ROWS_LOG2;
   localparam int ROW_W = 8 * BPP;
   localparam int TW    = MC + 2;
   localparam int PCW   = $clog2(LINE_W + 1);

   typedef enum logic [2:0] {IDLE, MAP, ROM, LOAD, HOLD} state_t;
   state_t state_q, state_d;

   logic              line_q;
   logic [MR-1:0]     row_q;
   logic [2:0]        fy_q, fx_q;
   logic [MC-1:0]     col_q;
   logic [TW-1:0]     tiles_left_q, tiles_left_d;
   logic [MC+MR-1:0]  map_addr_q;
   logic [CODE_W+2:0] rom_addr_q;
   logic              ent_inv_q;
   logic [ROW_W-1:0]  buf_q, sh_q;
   logic              buf_inv_q, buf_full_q, buf_full_d;
   logic              sh_inv_q, first_q, primed_q, primed_d;
   logic [3:0]        sh_cnt_q, sh_cnt_d, sh_left;
   logic [PCW-1:0]    pix_cnt_q;

   logic              pixel_valid, consume, last_pix, xfer;
   logic [MR+2:0]     wy;
   logic [TW-1:0]     tiles_tot;
   logic [2:0]        fy_eff;
   logic [CODE_W+2:0] rom_req;
   logic [ROW_W-1:0]  row_in;
   logic              unused_map;

`ifdef TILE_LAYER_FLIP_EN
   logic ent_hflip_q;

   function automatic logic [ROW_W-1:0] hrev(input logic [ROW_W-1:0] r);
      for (int k = 0; k < 8; k++) hrev[k*BPP +: BPP] = r[(7-k)*BPP +: BPP];
   endfunction

   assign fy_eff = fy_q ^ {3{bus.map_data[13]}};
   assign row_in = ent_hflip_q ? hrev(bus.rom_data) : bus.rom_data;
`else
   assign fy_eff = fy_q;
   assign row_in = bus.rom_data;
`endif

   assign unused_map = ^bus.map_data;
   assign wy         = bus.line_y + bus.scroll_y;
   assign tiles_tot  = TW'((LINE_W + 7 + int'(bus.scroll_x[2:0])) / 8);
   assign rom_req    = {bus.map_data[CODE_W-1:0], fy_eff};

   // Shifter/buffer bookkeeping: the buffer refills the shifter on the cycle it runs dry,
   // and the stream only opens once a tile is queued behind the one being shown.
   always_comb begin
      pixel_valid  = line_q && primed_q && (sh_cnt_q != 4'd0);
      consume      = pixel_valid && bus.pix_en;
      last_pix     = consume && (pix_cnt_q == PCW'(LINE_W - 1));
      sh_left      = sh_cnt_q - {3'd0, consume};
      xfer         = line_q && buf_full_q && (sh_left == 4'd0);
      sh_cnt_d     = sh_left;
      if (xfer) sh_cnt_d = first_q ? (4'd8 - {1'b0, fx_q}) : 4'd8;
      buf_full_d   = (buf_full_q && !xfer) || (state_q == LOAD);
      tiles_left_d = tiles_left_q - ((state_q == LOAD) ? TW'(1) : TW'(0));
      primed_d     = primed_q || ((sh_cnt_d != 4'd0) && (buf_full_d || (tiles_left_d == '0)));
   end

   // Fetch sequencing; a new line_start always restarts at MAP, a finished line parks in IDLE.
   always_comb begin
      state_d         = state_q;
      bus.map_addr    = map_addr_q;
      bus.rom_addr    = rom_addr_q;
      bus.pixel_valid = pixel_valid;
      bus.pixel_data  = '0;
      bus.busy        = line_q;
      case (state_q)
         IDLE: state_d = IDLE;
         MAP:  state_d = ROM;
         ROM:  begin
            state_d      = LOAD;
            bus.rom_addr = rom_req;
         end
         LOAD: state_d = (tiles_left_q == TW'(1)) ? IDLE : HOLD;
         HOLD: if (xfer) state_d = MAP;
         default: state_d = IDLE;
      endcase
      if (pixel_valid) bus.pixel_data = sh_q[ROW_W-1 -: BPP] ^ {BPP{sh_inv_q}};
      if (last_pix) state_d = IDLE;
      if (bus.line_start) state_d = MAP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         line_q       <= 1'b0;
         row_q        <= '0;
         fy_q         <= '0;
         fx_q         <= '0;
         col_q        <= '0;
         tiles_left_q <= '0;
         map_addr_q   <= '0;
         rom_addr_q   <= '0;
         ent_inv_q    <= 1'b0;
         buf_q        <= '0;
         buf_inv_q    <= 1'b0;
         buf_full_q   <= 1'b0;
         sh_q         <= '0;
         sh_inv_q     <= 1'b0;
         sh_cnt_q     <= '0;
         first_q      <= 1'b0;
         primed_q     <= 1'b0;
         pix_cnt_q    <= '0;
`ifdef TILE_LAYER_FLIP_EN
         ent_hflip_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (bus.line_start) begin
            line_q       <= 1'b1;
            row_q        <= wy[MR+2:3];
            fy_q         <= wy[2:0];
            fx_q         <= bus.scroll_x[2:0];
            map_addr_q   <= {wy[MR+2:3], bus.scroll_x[MC+2:3]};
            col_q        <= bus.scroll_x[MC+2:3] + 1'b1;
            tiles_left_q <= tiles_tot;
            buf_full_q   <= 1'b0;
            sh_q         <= '0;
            sh_inv_q     <= 1'b0;
            sh_cnt_q     <= '0;
            first_q      <= 1'b1;
            primed_q     <= 1'b0;
            pix_cnt_q    <= '0;
         end else if (last_pix) begin
            line_q     <= 1'b0;
            buf_full_q <= 1'b0;
            sh_cnt_q   <= '0;
            primed_q   <= 1'b0;
            pix_cnt_q  <= '0;
         end else begin
            if (state_q == HOLD && xfer) begin
               map_addr_q <= {row_q, col_q};
               col_q      <= col_q + 1'b1;
            end
            if (state_q == ROM) begin
               rom_addr_q  <= rom_req;
               ent_inv_q   <= bus.map_data[15];
`ifdef TILE_LAYER_FLIP_EN
               ent_hflip_q <= bus.map_data[14];
`endif
            end
            if (state_q == LOAD) begin
               buf_q     <= row_in;
               buf_inv_q <= ent_inv_q;
            end
            if (xfer) begin
               sh_q     <= first_q ? (buf_q << (BPP * int'(fx_q))) : buf_q;
               sh_inv_q <= buf_inv_q;
               first_q  <= 1'b0;
            end else if (consume) begin
               sh_q <= sh_q << BPP;
            end
            if (consume) pix_cnt_q <= pix_cnt_q + 1'b1;
            buf_full_q   <= buf_full_d;
            sh_cnt_q     <= sh_cnt_d;
            tiles_left_q <= tiles_left_d;
            primed_q     <= primed_d;
         end
      end
   end
endmodule
